// File: rtl/sample_frame_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sample_frame_scheduler_pkg                               |
// | Purpose : Shared types and constants for the sample frame scheduler |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package sample_frame_scheduler_pkg;

  localparam int VOICE_ID_W = 8;
  localparam logic [VOICE_ID_W-1:0] LAST_SLOT = 8'hFF;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_frame_scheduler_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sample_fifo                                              |
// | Purpose : Synchronous FIFO with registered head and overflow flag  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    overflow = push && full && !do_pop;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
      // Head is kept registered; bypass the write when it lands at the front.
      if (do_pop) begin
        if (count > CW'(1)) head <= mem[rd_ptr + AW'(1)];
        else if (do_push)   head <= push_data;
      end else if (empty && do_push) begin
        head <= push_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sample_frame_scheduler                                   |
// | Purpose : Issues one operator-slot frame per sample period and     |
// |           buffers the finished sample for the DAC serializer       |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module sample_frame_scheduler
  import sample_frame_scheduler_pkg::*;
#(
  parameter int CLOCKS_PER_SAMPLE = 1024,
  parameter int NUM_SLOTS         = 256,
  parameter int DRAIN_TIMEOUT     = 32,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Enable,
  input  logic                         i_ClearFlags,
  output logic [VOICE_ID_W-1:0]        o_VoiceOperator,
  output logic                         o_SlotValid,
  input  logic                         i_SampleReady,
  input  logic signed [SAMPLE_W-1:0]   i_Sample,
  output logic signed [SAMPLE_W-1:0]   o_DacSample,
  output logic                         o_DacValid,
  input  logic                         i_DacReady,
  output logic                         o_FrameActive,
  output logic                         o_Overrun,
  output logic                         o_DrainTimeout,
  output logic                         o_FifoOverflow
);
  localparam int PW = $clog2(CLOCKS_PER_SAMPLE);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0]         PERIOD_LAST = PW'(CLOCKS_PER_SAMPLE - 1);
  localparam logic [VOICE_ID_W-1:0] SLOT_LAST   = VOICE_ID_W'(NUM_SLOTS - 1);
  localparam logic [DW-1:0]         DRAIN_LAST  = DW'(DRAIN_TIMEOUT - 1);

  sched_state_t          state;
  logic [PW-1:0]         period_cnt;
  logic [VOICE_ID_W-1:0] slot_cnt;
  logic [DW-1:0]         drain_cnt;
  logic                  counting;
  logic                  tick;
  logic                  push;
  logic                  pop;
  logic                  timeout_set;
  logic                  overrun_set;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_overflow;
  logic                  fifo_full_unused;
  logic [CW-1:0]         fifo_count;
  logic [SAMPLE_W-1:0]   fifo_head;

  always_comb begin
    counting    = i_Enable || (state != IDLE);
    tick        = counting && (period_cnt == PERIOD_LAST);
    push        = (state == DRAIN) && i_SampleReady;
    timeout_set = (state == DRAIN) && !i_SampleReady && (drain_cnt == DRAIN_LAST);
    overrun_set = tick && ((state == ISSUE) || (state == DRAIN));
    pop         = i_DacReady && !fifo_empty;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset || !counting || tick) period_cnt <= '0;
    else                              period_cnt <= period_cnt + PW'(1);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      slot_cnt    <= '0;
      drain_cnt   <= '0;
      o_SlotValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && i_Enable) begin
            state       <= ISSUE;
            o_SlotValid <= 1'b1;
          end
        end
        ISSUE: begin
          if (slot_cnt == SLOT_LAST) begin
            state       <= DRAIN;
            slot_cnt    <= '0;
            drain_cnt   <= '0;
            o_SlotValid <= 1'b0;
          end else begin
            slot_cnt <= slot_cnt + VOICE_ID_W'(1);
          end
        end
        DRAIN: begin
          if (push || timeout_set) state <= WAIT;
          else                     drain_cnt <= drain_cnt + DW'(1);
        end
        WAIT: begin
          // Enable is only consulted here, so a frame in flight always completes.
          if (tick) begin
            if (i_Enable) begin
              state       <= ISSUE;
              o_SlotValid <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Overrun      <= 1'b0;
      o_DrainTimeout <= 1'b0;
      o_FifoOverflow <= 1'b0;
    end else begin
      if (overrun_set)       o_Overrun <= 1'b1;
      else if (i_ClearFlags) o_Overrun <= 1'b0;
      if (timeout_set)       o_DrainTimeout <= 1'b1;
      else if (i_ClearFlags) o_DrainTimeout <= 1'b0;
      if (fifo_overflow)     o_FifoOverflow <= 1'b1;
      else if (i_ClearFlags) o_FifoOverflow <= 1'b0;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (i_Clock),
    .rst       (i_Reset),
    .push      (push),
    .push_data (i_Sample),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_overflow)
  );

  assign fifo_full_unused = fifo_full;
  assign o_VoiceOperator  = slot_cnt;
  assign o_DacSample      = fifo_head;
  assign o_DacValid       = (fifo_count != '0);
  assign o_FrameActive    = (state == ISSUE) || (state == DRAIN);

endmodule
`default_nettype wire
